// File: rtl/seg_digit_render.sv
// seg_digit_render: overlays a row of 7-segment hex digits on an RGB565 video stream.
// Host writes land in shadow digit registers and are committed at the vsync fall.
// Optional blink support is compiled in with `define SEG_DIGIT_BLINK_EN.
module seg_digit_render #(
  parameter int          H_START    = 182,
  parameter int          NUM_DIGITS = 8,
  parameter int          ORIGIN_X   = 64,
  parameter int          ORIGIN_Y   = 64,
  parameter int          DIGIT_W    = 48,
  parameter int          DIGIT_H    = 80,
  parameter int          DIGIT_GAP  = 16,
  parameter int          SEG_T      = 8,
  parameter logic [15:0] FG         = 16'h07E0,
  parameter logic [15:0] BG         = 16'h0000
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic [15:0] PixelCount,
  input  logic [15:0] LineCount,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [5:0]  wr_data,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic        LCD_DE,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC
);
  localparam logic [15:0] L_H_START  = 16'(H_START);
  localparam logic [15:0] L_OX       = 16'(ORIGIN_X);
  localparam logic [15:0] L_OY       = 16'(ORIGIN_Y);
  localparam logic [15:0] L_Y_END    = 16'(ORIGIN_Y + DIGIT_H);
  localparam logic [15:0] L_W_LAST   = 16'(DIGIT_W - 1);
  localparam logic [15:0] L_GAP_LAST = 16'((DIGIT_GAP > 0) ? (DIGIT_GAP - 1) : 0);
  localparam bit          L_HAS_GAP  = (DIGIT_GAP > 0);
  localparam logic [3:0]  L_ND       = 4'(NUM_DIGITS);
  localparam logic [15:0] L_T        = 16'(SEG_T);
  localparam logic [15:0] L_W        = 16'(DIGIT_W);
  localparam logic [15:0] L_W_T      = 16'(DIGIT_W - SEG_T);
  localparam logic [15:0] L_H        = 16'(DIGIT_H);
  localparam logic [15:0] L_H_T      = 16'(DIGIT_H - SEG_T);
  localparam logic [15:0] L_HALF     = 16'(DIGIT_H / 2);
  localparam logic [15:0] L_G_TOP    = 16'(DIGIT_H / 2 - SEG_T / 2);
  localparam logic [15:0] L_G_BOT    = 16'(DIGIT_H / 2 + SEG_T / 2);
  localparam logic [5:0]  L_BLANK    = 6'b010000;

  // Standard 7-segment pattern for a hex value; bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] f_hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Which segment areas cover cell-local pixel (cx, cy); same bit order as f_hex_to_seg.
  function automatic logic [6:0] f_seg_hit(input logic [15:0] cx, input logic [15:0] cy);
    logic       mid_col, left_col, right_col, upper, lower;
    logic [6:0] hit;
    mid_col   = (cx >= L_T) && (cx < L_W_T);
    left_col  = (cx < L_T);
    right_col = (cx >= L_W_T) && (cx < L_W);
    upper     = (cy >= L_T) && (cy < L_HALF);
    lower     = (cy >= L_HALF) && (cy < L_H_T);
    hit[0] = mid_col && (cy < L_T);
    hit[1] = right_col && upper;
    hit[2] = right_col && lower;
    hit[3] = mid_col && (cy >= L_H_T) && (cy < L_H);
    hit[4] = left_col && lower;
    hit[5] = left_col && upper;
    hit[6] = mid_col && (cy >= L_G_TOP) && (cy < L_G_BOT);
    return hit;
  endfunction

  logic [5:0]  r_shadow [8];
  logic [5:0]  r_active [8];
  logic        r_de_prev, r_vs_prev;
  logic [15:0] r_cx;
  logic        r_gap;
  logic [3:0]  r_dig;
  logic [15:0] r_p1_rgb, r_rgb;
  logic        r_p1_de, r_p1_hs, r_p1_vs, r_de, r_hs, r_vs;

  logic        w_de_rise, w_commit, w_wr_ok, w_adv, w_y_in, w_in_cell;
  logic        w_lit, w_blank, w_blink_off;
  logic [15:0] w_x, w_cy, w_cx, w_cx_n, w_rgb;
  logic        w_gap, w_gap_n;
  logic [3:0]  w_dig, w_dig_n;
  logic [5:0]  w_digit;

  assign w_de_rise = de_in & ~r_de_prev;
  assign w_commit  = r_vs_prev & ~vs_in;
  assign w_wr_ok   = wr_en && ({1'b0, wr_addr} < L_ND);

  // Counters restart for the pixel that raises DE, so the first active pixel sees zero.
  assign w_cx  = w_de_rise ? 16'd0 : r_cx;
  assign w_gap = w_de_rise ? 1'b0  : r_gap;
  assign w_dig = w_de_rise ? 4'd0  : r_dig;

  assign w_x    = PixelCount - L_H_START;
  assign w_adv  = de_in && (PixelCount >= L_H_START) && (w_x >= L_OX) && (w_dig < L_ND);
  assign w_cy   = LineCount - L_OY;
  assign w_y_in = (LineCount >= L_OY) && (LineCount < L_Y_END);

`ifdef SEG_DIGIT_BLINK_EN
  logic [5:0] r_frame;

  // Frame counter advances once per committed frame and drives the blink phase.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_frame <= 6'd0;
    end else if (w_commit) begin
      r_frame <= r_frame + 6'd1;
    end else begin
      r_frame <= r_frame;
    end
  end

  assign w_blink_off = r_frame[5];
`else
  assign w_blink_off = 1'b0;
`endif

  // Shadow digits take host writes; active digits reload from the pre-write shadow at the vsync fall.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= L_BLANK;
        r_active[i] <= L_BLANK;
      end
    end else begin
      if (w_commit) begin
        for (int i = 0; i < 8; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (w_wr_ok) begin
        r_shadow[wr_addr] <= wr_data;
      end
    end
  end

  // Edge-detect history for DE (line start) and VSYNC (frame commit).
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_de_prev <= 1'b0;
      r_vs_prev <= 1'b1;
    end else begin
      r_de_prev <= de_in;
      r_vs_prev <= vs_in;
    end
  end

  // Step column-in-cell / gap / digit index by one pixel; digit index saturates past the row.
  always_comb begin
    w_cx_n  = w_cx;
    w_gap_n = w_gap;
    w_dig_n = w_dig;
    if (w_adv) begin
      if (w_gap) begin
        if (w_cx == L_GAP_LAST) begin
          w_cx_n  = 16'd0;
          w_gap_n = 1'b0;
          w_dig_n = w_dig + 4'd1;
        end else begin
          w_cx_n = w_cx + 16'd1;
        end
      end else if (w_cx == L_W_LAST) begin
        w_cx_n = 16'd0;
        if (L_HAS_GAP) begin
          w_gap_n = 1'b1;
        end else begin
          w_dig_n = w_dig + 4'd1;
        end
      end else begin
        w_cx_n = w_cx + 16'd1;
      end
    end else begin
      w_cx_n  = w_cx;
      w_gap_n = w_gap;
      w_dig_n = w_dig;
    end
  end

  // Horizontal position counters.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_cx  <= 16'd0;
      r_gap <= 1'b0;
      r_dig <= 4'd0;
    end else begin
      r_cx  <= w_cx_n;
      r_gap <= w_gap_n;
      r_dig <= w_dig_n;
    end
  end

  assign w_digit   = r_active[w_dig[2:0]];
  assign w_blank   = w_digit[4] | (w_digit[5] & w_blink_off);
  assign w_in_cell = w_adv & ~w_gap & w_y_in;
  assign w_lit     = |(f_seg_hit(w_cx, w_cy) & f_hex_to_seg(w_digit[3:0]));
  assign w_rgb     = de_in ? ((w_in_cell && w_lit && !w_blank) ? FG : BG) : 16'h0000;

  // Two-stage output pipeline; syncs travel alongside the colour.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_p1_rgb <= 16'h0000;
      r_p1_de  <= 1'b0;
      r_p1_hs  <= 1'b1;
      r_p1_vs  <= 1'b1;
      r_rgb    <= 16'h0000;
      r_de     <= 1'b0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
    end else begin
      r_p1_rgb <= w_rgb;
      r_p1_de  <= de_in;
      r_p1_hs  <= hs_in;
      r_p1_vs  <= vs_in;
      r_rgb    <= r_p1_rgb;
      r_de     <= r_p1_de;
      r_hs     <= r_p1_hs;
      r_vs     <= r_p1_vs;
    end
  end

  assign LCD_R     = r_rgb[15:11];
  assign LCD_G     = r_rgb[10:5];
  assign LCD_B     = r_rgb[4:0];
  assign LCD_DE    = r_de;
  assign LCD_HSYNC = r_hs;
  assign LCD_VSYNC = r_vs;
endmodule

// File: tb/tb_seg_digit_render.sv
// Bench for seg_digit_render: reference model derives each pixel from the cell geometry
// with division/modulo and segment letter tables, compared two cycles later.
module tb_seg_digit_render;
  localparam int HS = 182, ND = 4, OX = 64, OY = 64, W = 48, H = 80, G = 16, T = 8;
  localparam int ROW_END = OX + ND * (W + G) - G;
  localparam int SPAN = ROW_END + 8;
  localparam logic [15:0] FG_C = 16'h07E0, BG_C = 16'h0000;
  localparam logic [18:0] RST_V = {16'h0000, 1'b0, 1'b1, 1'b1};

  logic clk = 1'b0, nrst, de, hs, vs, we;
  logic [15:0] pc, lc;
  logic [2:0] wa;
  logic [5:0] wd;
  logic [4:0] o_r, o_b;
  logic [5:0] o_g;
  logic o_de, o_hs, o_vs;

  seg_digit_render #(.H_START(HS), .NUM_DIGITS(ND), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .DIGIT_W(W), .DIGIT_H(H), .DIGIT_GAP(G), .SEG_T(T), .FG(FG_C), .BG(BG_C)) dut (
    .PixelClk(clk), .nRST(nrst), .PixelCount(pc), .LineCount(lc),
    .de_in(de), .hs_in(hs), .vs_in(vs), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .LCD_R(o_r), .LCD_G(o_g), .LCD_B(o_b), .LCD_DE(o_de), .LCD_HSYNC(o_hs), .LCD_VSYNC(o_vs));

  always #5 clk = ~clk;

  string seg_pats [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  logic [5:0] m_sh [8];
  logic [5:0] m_act [8];
  int m_commits;
  logic m_vs_prev;
  logic [18:0] e_prev, e_cur;
  int n_cmp = 0, n_bad = 0;
  int p_x, p_y, pr_x, pr_y;
  logic p_de, pr_en, pr_hit;
  logic [15:0] pr_val;

  function automatic byte seg_at(int cx, int cy);
    if (cx >= T && cx < W - T) begin
      if (cy < T) return "a";
      if (cy >= H / 2 - T / 2 && cy < H / 2 + T / 2) return "g";
      if (cy >= H - T && cy < H) return "d";
    end
    if (cx < T) begin
      if (cy >= T && cy < H / 2) return "f";
      if (cy >= H / 2 && cy < H - T) return "e";
    end
    if (cx >= W - T && cx < W) begin
      if (cy >= T && cy < H / 2) return "b";
      if (cy >= H / 2 && cy < H - T) return "c";
    end
    return 8'd0;
  endfunction

  function automatic logic [15:0] ref_pix(int x, int y);
    int rel, d, cx, cy;
    byte s;
    logic [5:0] dg;
    string p;
    if (x < OX || x >= ROW_END || y < OY || y >= OY + H) return BG_C;
    rel = x - OX;
    d = rel / (W + G);
    cx = rel % (W + G);
    if (cx >= W) return BG_C;
    cy = y - OY;
    dg = m_act[d];
    if (dg[4]) return BG_C;
`ifdef SEG_DIGIT_BLINK_EN
    if (dg[5] && ((m_commits / 32) % 2 == 1)) return BG_C;
`endif
    s = seg_at(cx, cy);
    if (s == 8'd0) return BG_C;
    p = seg_pats[dg[3:0]];
    for (int i = 0; i < p.len(); i++) if (p.getc(i) == s) return FG_C;
    return BG_C;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_sh[i] = 6'b010000;
      m_act[i] = 6'b010000;
    end
    m_commits = 0;
    m_vs_prev = 1'b1;
    p_de = 1'b0;
  endtask

  task automatic tick();
    logic [18:0] obs;
    int x, cx_cur, cy_cur;
    logic cde;
    cx_cur = 0; cy_cur = 0; cde = 1'b0;
    if (!nrst) begin
      model_reset();
      e_cur = RST_V;
      e_prev = RST_V;
    end else begin
      x = int'(pc) - HS;
      e_cur = {(de ? ref_pix(x, int'(lc)) : 16'h0000), de, hs, vs};
      cx_cur = x; cy_cur = int'(lc); cde = de;
      if (m_vs_prev && !vs) begin
        for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
        m_commits++;
      end
      m_vs_prev = vs;
      if (we && int'(wa) < ND) m_sh[wa] = wd;
    end
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    obs = {o_r, o_g, o_b, o_de, o_hs, o_vs};
    n_cmp++;
    assert (obs === e_prev) else begin
      n_bad++;
      $error("FAIL pix x=%0d y=%0d got %h exp %h", p_x, p_y, obs, e_prev);
    end
    if (pr_en && p_de && p_x == pr_x && p_y == pr_y) begin
      pr_hit = 1'b1;
      pr_val = obs[18:3];
    end
    e_prev = e_cur;
    p_x = cx_cur; p_y = cy_cur; p_de = cde;
  endtask

  task automatic run_line(int y, int de_len, bit rand_wr);
    lc = 16'(y);
    for (int p = 0; p < de_len + 8; p++) begin
      pc = 16'(HS - 4 + p);
      de = (p >= 4 && p < 4 + de_len);
      hs = !(p >= de_len + 5 && p < de_len + 7);
      if (rand_wr && $urandom_range(0, 63) == 0) begin
        we = 1'b1;
        wa = 3'($urandom_range(0, 7));
        wd = 6'($urandom);
      end
      tick();
    end
    de = 1'b0;
    hs = 1'b1;
  endtask

  task automatic vsync(bit w, logic [2:0] a, logic [5:0] d);
    vs = 1'b0;
    if (w) begin
      we = 1'b1; wa = a; wd = d;
    end
    tick(); tick(); tick();
    vs = 1'b1;
    tick();
  endtask

  task automatic probe(string tag, int x, int y, int de_len, logic [15:0] exp_v);
    pr_x = x; pr_y = y; pr_en = 1'b1; pr_hit = 1'b0; pr_val = 16'hxxxx;
    run_line(y, de_len, 1'b0);
    pr_en = 1'b0;
    n_cmp++;
    assert (pr_hit && pr_val === exp_v) else begin
      n_bad++;
      $error("FAIL %s got %h exp %h", tag, pr_val, exp_v);
    end
  endtask

  task automatic write_digit(logic [2:0] a, logic [5:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
  endtask

  initial begin
    int found;
    logic [15:0] bexp;
    nrst = 1'b0; de = 1'b0; hs = 1'b1; vs = 1'b1; we = 1'b0; wa = 3'd0; wd = 6'd0;
    pc = 16'd0; lc = 16'd0; pr_en = 1'b0; pr_hit = 1'b0; pr_val = 16'h0000;
    p_x = 0; p_y = 0; pr_x = 0; pr_y = 0;
    model_reset();
    e_prev = RST_V;
    @(negedge clk);
    repeat (3) tick();
    n_cmp++;
    assert ({o_r, o_g, o_b} === 16'h0000 && o_de === 1'b0) else begin
      n_bad++; $error("FAIL rst_rgb_de got %h/%b exp 0000/0", {o_r, o_g, o_b}, o_de);
    end
    n_cmp++;
    assert (o_hs === 1'b1 && o_vs === 1'b1) else begin
      n_bad++; $error("FAIL rst_sync got %b%b exp 11", o_hs, o_vs);
    end
    nrst = 1'b1;
    tick();

    // Blank frame after reset.
    vsync(1'b0, 3'd0, 6'd0);
    probe("blank_a", OX + 24, OY + 2, SPAN, 16'h0000);
    run_line(OY - 1, SPAN, 1'b0);
    run_line(OY + H - 1, SPAN, 1'b0);
    run_line(OY + H, SPAN, 1'b0);

    // Digit 0 = 8: written now, visible only after the commit.
    write_digit(3'd0, 6'h08);
    probe("no_tear", OX + 24, OY + 2, SPAN, 16'h0000);
    vsync(1'b0, 3'd0, 6'd0);
    probe("seg_a", OX + 24, OY + 2, SPAN, 16'h07E0);
    probe("mid_bg", OX + 24, OY + 20, SPAN, 16'h0000);
    probe("seg_g", OX + 24, OY + 38, SPAN, 16'h07E0);

    // Write coinciding with the commit lands one frame later.
    vsync(1'b1, 3'd1, 6'h01);
    probe("d1_hold", OX + 64 + 44, OY + 20, SPAN, 16'h0000);
    vsync(1'b0, 3'd0, 6'd0);
    probe("d1_b", OX + 64 + 44, OY + 20, SPAN, 16'h07E0);
    probe("d1_c", OX + 64 + 44, OY + 50, SPAN, 16'h07E0);
    probe("d1_a_off", OX + 64 + 24, OY + 2, SPAN, 16'h0000);

    // Out-of-range digit address changes nothing.
    write_digit(3'd7, 6'h08);
    write_digit(3'd4, 6'h08);
    vsync(1'b0, 3'd0, 6'd0);
    probe("addr7_d0", OX + 24, OY + 2, SPAN, 16'h07E0);
    probe("past_row", ROW_END + 2, OY + 2, SPAN, 16'h0000);
    probe("gap_bg", OX + W + 4, OY + 2, SPAN, 16'h0000);

    // Single-cycle DE pulse: LCD_DE two cycles later.
    lc = 16'(OY + 2);
    pc = 16'(HS + OX);
    de = 1'b1;
    tick();
    de = 1'b0;
    found = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (found < 0 && o_de === 1'b1) found = k;
    end
    n_cmp++;
    assert (found === 1) else begin
      n_bad++; $error("FAIL de_latency got %0d exp 1", found);
    end

    // Truncated DE rows.
    run_line(OY + 2, 100, 1'b0);
    run_line(OY + 2, SPAN, 1'b0);

    // Reset mid-frame blanks until the next commit.
    run_line(OY + 30, SPAN, 1'b1);
    nrst = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    tick();
    probe("rst_blank", OX + 24, OY + 2, SPAN, 16'h0000);

    // Randomized frames.
    for (int f = 0; f < 16; f++) begin
      vsync($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 6'($urandom));
      run_line($urandom_range(OY - 2, OY + H + 1), $urandom_range(100, SPAN), 1'b1);
      run_line($urandom_range(OY - 2, OY + H + 1), $urandom_range(100, SPAN), 1'b1);
    end

    // Blinking digit 0 over 70 frames.
    write_digit(3'd0, 6'h28);
    for (int f = 0; f < 70; f++) begin
      vsync(1'b0, 3'd0, 6'd0);
      bexp = 16'h07E0;
`ifdef SEG_DIGIT_BLINK_EN
      if ((m_commits / 32) % 2 == 1) bexp = 16'h0000;
`endif
      probe("blink", OX + 24, OY + 2, 96, bexp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_digit_render.md
SEG_DIGIT_RENDER -- requirements
Module: seg_digit_render

Interface
REQ-001 SHALL have parameter H_START, default 182, PixelCount value of the first active column.
REQ-002 SHALL have parameter NUM_DIGITS, default 8, digits in the rendered row (range 1..8).
REQ-003 SHALL have parameters ORIGIN_X, default 64, and ORIGIN_Y, default 64, the digit-row top-left corner in active-area pixels.
REQ-004 SHALL have parameters DIGIT_W, default 48, DIGIT_H, default 80, and DIGIT_GAP, default 16; cell size and inter-digit gap in pixels.
REQ-005 SHALL have parameter SEG_T, default 8, segment thickness in pixels.
REQ-006 SHALL have parameters FG, default 16'h07E0, and BG, default 16'h0000, RGB565 lit-segment and background colours.
REQ-007 PixelClk  input  1  pixel clock; all state on its rising edge.
REQ-008 nRST  input  1  asynchronous, active-low reset.
REQ-009 PixelCount  input  16  horizontal counter from the timing generator.
REQ-010 LineCount  input  16  vertical counter from the timing generator.
REQ-011 de_in, hs_in, vs_in  input  1 each  timing-generator DE (active-high), HSYNC and VSYNC (active-low).
REQ-012 wr_en  input  1  single-cycle digit write strobe.
REQ-013 wr_addr  input  3  digit index; 0 is leftmost.
REQ-014 wr_data  input  6  [5] blink, [4] blank, [3:0] hex value.
REQ-015 LCD_R 5, LCD_G 6, LCD_B 5, LCD_DE 1, LCD_HSYNC 1, LCD_VSYNC 1  outputs  panel drive.

Function
REQ-016 SHALL keep shadow and active copies of each digit register; wr_en writes shadow[wr_addr] in the same cycle.
REQ-017 SHALL ignore writes with wr_addr >= NUM_DIGITS.
REQ-018 SHALL copy all shadow registers to the active registers on the cycle vs_in falls (registered 1->0), so a frame never tears.
REQ-019 A write coinciding with the commit cycle SHALL update shadow only; the commit takes the pre-write value, so the write appears one frame later.
REQ-020 SHALL track position with counters, not dividers: column-in-cell, gap flag and digit index reset on the de_in rising edge and advance once per de_in cycle; line-in-cell counts lines from ORIGIN_Y.
REQ-021 Pixel is in-cell when ORIGIN_X <= x < ORIGIN_X+NUM_DIGITS*(DIGIT_W+DIGIT_GAP)-DIGIT_GAP, outside any gap, and ORIGIN_Y <= y < ORIGIN_Y+DIGIT_H, where x = PixelCount-H_START.
REQ-022 Segments (cx,cy local to cell, T = SEG_T, H = DIGIT_H, W = DIGIT_W): a = rows [0,T), cols [T,W-T); g = rows [H/2-T/2, H/2+T/2), cols [T,W-T); d = rows [H-T,H), cols [T,W-T); f/b = cols [0,T)/[W-T,W), rows [T,H/2); e/c = the same columns, rows [H/2,H-T).
REQ-023 SHALL decode hex 0-F to standard 7-segment patterns (0 = abcdef, 1 = bc, 8 = all, A = abcefg, b = cdefg, C = adef, d = bcdeg, E = adefg, F = aefg).
REQ-024 Output colour SHALL be FG on a lit segment of a non-blank digit, otherwise BG; it SHALL be 16'h0000 when the delayed DE is 0.
REQ-025 Pipeline latency SHALL be exactly 2 PixelClk cycles; LCD_DE, LCD_HSYNC and LCD_VSYNC SHALL be de_in, hs_in and vs_in delayed 2 cycles, aligned with RGB.
REQ-026 A de_in pulse shorter than the row width SHALL simply truncate the row, with no wrap into the next line.

Reset
REQ-027 On nRST low: RGB, LCD_DE and all pipeline registers = 0; LCD_HSYNC and LCD_VSYNC = 1; shadow and active digits = blank (6'b010000); frame counter = 0.
REQ-028 Reset mid-frame SHALL produce blank digits until the first vs_in fall after release.

Configuration
REQ-029 With SEG_DIGIT_BLINK_EN defined: a 6-bit frame counter increments on every commit, and digits with blink = 1 render as blank while counter[5] = 1.
REQ-030 Without SEG_DIGIT_BLINK_EN: no frame counter exists and the blink bit is ignored.

Verification
REQ-031 Reset, then no writes for a full frame -> every active pixel 16'h0000; LCD_HSYNC/LCD_VSYNC mirror the inputs 2 cycles later.
REQ-032 Write addr 0 data 6'h08, then one vs_in fall -> next frame pixel (x=64+24, y=64+2) = 16'h07E0 (segment a) and (x=64+24, y=64+20) = 16'h0000.
REQ-033 Write addr 1 data 6'h01 in the same cycle vs_in falls -> digit 1 is still blank that frame and shows '1' (segments b,c) the following frame.
REQ-034 Write wr_addr = 7 with NUM_DIGITS = 4 -> no pixel change in any frame.
REQ-035 Pulse de_in at a known cycle N -> LCD_DE rises at cycle N+2 and RGB is valid on that same cycle.
REQ-036 With SEG_DIGIT_BLINK_EN, digit 0 = 6'h28 -> lit for 32 frames, then blank for 32 frames, then repeats.
